// File: rtl/shake_arbiter_if.sv
// Requester-side and core-side handshake bundle for the SHAKE core arbiter.
// slave = arbiter view, master = view of the environment (samplers + core).
interface shake_arbiter_if #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned DATA_IN_BITS  = 64,
    parameter int unsigned DATA_OUT_BITS = 64
);
    localparam int unsigned LEN_W = $clog2(DATA_IN_BITS) + 1;

    // requester side
    logic [NUM_REQ-1:0]              req;
    logic [NUM_REQ-1:0]              grant;
    logic [NUM_REQ-1:0]              req_absorb_next;
    logic [NUM_REQ*DATA_IN_BITS-1:0] req_data_in;
    logic [NUM_REQ-1:0]              req_in_valid;
    logic [NUM_REQ-1:0]              req_in_last;
    logic [NUM_REQ*LEN_W-1:0]        req_last_len;
    logic [NUM_REQ-1:0]              req_out_ready;
    logic [NUM_REQ-1:0]              req_in_ready;
    logic [NUM_REQ-1:0]              req_out_valid;
    logic [DATA_OUT_BITS-1:0]        req_data_out;

    // core side
    logic                            shake_force_rst;
    logic                            shake_mode;
    logic [DATA_IN_BITS-1:0]         shake_data_in;
    logic                            shake_in_valid;
    logic                            shake_in_last;
    logic [LEN_W-1:0]                shake_last_len;
    logic                            shake_out_ready;
    logic [DATA_OUT_BITS-1:0]        shake_data_out;
    logic                            shake_out_valid;
    logic                            shake_in_ready;

    modport slave (
        input  req, req_absorb_next, req_data_in, req_in_valid, req_in_last,
               req_last_len, req_out_ready,
               shake_data_out, shake_out_valid, shake_in_ready,
        output grant, req_in_ready, req_out_valid, req_data_out,
               shake_force_rst, shake_mode, shake_data_in, shake_in_valid,
               shake_in_last, shake_last_len, shake_out_ready
    );

    modport master (
        output req, req_absorb_next, req_data_in, req_in_valid, req_in_last,
               req_last_len, req_out_ready,
               shake_data_out, shake_out_valid, shake_in_ready,
        input  grant, req_in_ready, req_out_valid, req_data_out,
               shake_force_rst, shake_mode, shake_data_in, shake_in_valid,
               shake_in_last, shake_last_len, shake_out_ready
    );
endinterface

// File: rtl/shake_arbiter.sv
// Locked round-robin arbiter sharing one SHAKE128/256 core between sampler
// engines. Each grant is preceded by a one-cycle core flush and mode select;
// the owner keeps the core until it drops its request.
module shake_arbiter #(
    parameter int unsigned         NUM_REQ       = 4,
    parameter int unsigned         DATA_IN_BITS  = 64,
    parameter int unsigned         DATA_OUT_BITS = 64,
    parameter logic [NUM_REQ-1:0]  MODE_VEC      = NUM_REQ'(4'b0110)
) (
    input logic            clk,
    input logic            rst,
    shake_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned LEN_W = $clog2(DATA_IN_BITS) + 1;

    typedef enum logic [1:0] {IDLE, FLUSH, BUSY} state_t;

    state_t                   state;
    logic [IDX_W-1:0]         owner;
    logic [IDX_W-1:0]         rr_ptr;
    logic [IDX_W-1:0]         rr_next;
    logic [IDX_W-1:0]         winner;
    logic                     found;
    int unsigned              idx;
    logic                     flush;
    logic                     mode_q;
    logic [NUM_REQ-1:0]       grant_q;
    logic                     busy;
    logic [DATA_OUT_BITS-1:0] data_out;

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_ptr) + i) % NUM_REQ;
            if (!found && bus.req[idx]) begin
                winner = IDX_W'(idx);
                found  = 1'b1;
            end
        end
    end

    assign rr_next = (32'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;

    // Session FSM: IDLE picks and flushes, FLUSH confirms, BUSY holds until release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= '0;
            rr_ptr  <= '0;
            flush   <= 1'b0;
            mode_q  <= 1'b0;
            grant_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        owner  <= winner;
                        mode_q <= MODE_VEC[winner];
                        flush  <= 1'b1;
                        state  <= FLUSH;
                    end
                end
                FLUSH: begin
                    flush <= 1'b0;
                    if (bus.req[owner]) begin
                        grant_q <= NUM_REQ'(1) << owner;
                        state   <= BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (!bus.req[owner]) begin
                        grant_q <= '0;
                        rr_ptr  <= rr_next;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy             = (state == BUSY);
    assign data_out         = bus.shake_data_out;
    assign bus.req_data_out = data_out;
    assign bus.grant        = grant_q;
    assign bus.shake_mode   = mode_q;

    // Owner-slice mux to the core; everything is quiet outside a granted session.
    // In BUSY the force-reset is the owner's absorb_next, so re-absorb keeps the grant.
    always_comb begin
        bus.shake_data_in   = '0;
        bus.shake_in_valid  = 1'b0;
        bus.shake_in_last   = 1'b0;
        bus.shake_last_len  = '0;
        bus.shake_out_ready = 1'b0;
        bus.shake_force_rst = flush;
        bus.req_in_ready    = '0;
        bus.req_out_valid   = '0;
        if (busy) begin
            bus.shake_data_in        = bus.req_data_in[owner*DATA_IN_BITS +: DATA_IN_BITS];
            bus.shake_in_valid       = bus.req_in_valid[owner];
            bus.shake_in_last        = bus.req_in_last[owner];
            bus.shake_last_len       = bus.req_last_len[owner*LEN_W +: LEN_W];
            bus.shake_out_ready      = bus.req_out_ready[owner];
            bus.shake_force_rst      = bus.req_absorb_next[owner];
            bus.req_in_ready[owner]  = bus.shake_in_ready;
            bus.req_out_valid[owner] = bus.shake_out_valid;
        end
    end

    // Grant must be one-hot or zero, and only held while a session is active.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(grant_q));
            assert (state == BUSY || grant_q == '0);
        end
    end
endmodule

// File: doc/shake_arbiter.md
Name: shake_arbiter

Overview:
- Shares one SHAKE128/256 core among NUM_REQ sampler engines (ExpandA, ExpandS, ExpandMask, SampleInBall).
- Grants are round-robin and locked: one requester owns the core for its whole absorb/squeeze session.
- On every grant the block flushes the core with a one-cycle force-reset and selects the core mode for the new owner.

Parameters:
NUM_REQ, 4, number of requesters
DATA_IN_BITS, 64, core absorb word width
DATA_OUT_BITS, 64, core squeeze word width
MODE_VEC, 4'b0110, per-requester core mode; bit i=1 SHAKE256, 0 SHAKE128

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  NUM_REQ  session request, held high for the whole session
grant  out  NUM_REQ  one-hot owner, registered
req_absorb_next  in  NUM_REQ  per-requester core force-reset
req_data_in  in  NUM_REQ*DATA_IN_BITS  packed absorb words, slice i = requester i
req_in_valid  in  NUM_REQ  absorb valid
req_in_last  in  NUM_REQ  last absorb word
req_last_len  in  NUM_REQ*($clog2(DATA_IN_BITS)+1)  valid bits of last word
req_out_ready  in  NUM_REQ  squeeze ready
req_in_ready  out  NUM_REQ  demuxed core in_ready
req_out_valid  out  NUM_REQ  demuxed core out_valid
req_data_out  out  DATA_OUT_BITS  core squeeze data, broadcast to all requesters
shake_force_rst  out  1  core flush
shake_mode  out  1  1=SHAKE256, 0=SHAKE128, registered
shake_data_in  out  DATA_IN_BITS  to core
shake_in_valid  out  1  to core
shake_in_last  out  1  to core
shake_last_len  out  $clog2(DATA_IN_BITS)+1  to core
shake_out_ready  out  1  to core
shake_data_out  in  DATA_OUT_BITS  from core
shake_out_valid  in  1  from core
shake_in_ready  in  1  from core

Behaviour:
- Reset values:
  - grant=0, shake_force_rst=0, shake_mode=0, state=IDLE, rr_ptr=0.
  - All core-side outputs are 0, and every req_in_ready and req_out_valid is 0.
- States: IDLE, FLUSH, BUSY.
- IDLE, when any req bit is high:
  - Pick the winner: first set bit at or after rr_ptr, searching upward and wrapping at NUM_REQ-1 to 0.
  - Register owner. Set shake_mode<=MODE_VEC[owner] and shake_force_rst<=1.
  - Go to FLUSH.
- FLUSH (exactly 1 cycle, shake_force_rst high):
  - Next cycle: shake_force_rst<=0.
  - If req[owner] is still high: grant<=onehot(owner), go to BUSY.
  - Otherwise: go to IDLE with rr_ptr unchanged.
- Latency: a req sampled high in IDLE gives grant high 2 cycles later. The core has been reset before the first forwarded word.
- BUSY:
  - Combinational mux from the owner slice to shake_data_in, shake_in_valid, shake_in_last, shake_last_len and shake_out_ready.
  - shake_force_rst = req_absorb_next[owner], passed through so per-polynomial re-absorb works without releasing the grant.
  - req_in_ready[owner]=shake_in_ready and req_out_valid[owner]=shake_out_valid; all other bits are 0.
- Release: in BUSY, req[owner] sampled low gives:
  - grant<=0, rr_ptr<=owner+1 (mod NUM_REQ), go to IDLE.
  - Core-side valid/ready outputs go 0 combinationally while grant is 0.
- IDLE lasts at least one cycle between sessions, including release and a new request in the same cycle.
- Fairness: a requester continuously requesting waits for at most NUM_REQ-1 other sessions.
- Non-owner inputs are ignored entirely, including their req_absorb_next.
- In IDLE/FLUSH: shake_in_valid=0 and shake_out_ready=0, so no core transfer occurs.
- rst asserted mid-session returns to reset values on the next edge; in-flight core data is discarded.
- Assertions: grant is one-hot or zero; grant is never high in IDLE or FLUSH.

Test Plan:
- Single requester: req=0100 at cycle 0 → shake_force_rst high at cycle 1, shake_mode=1, grant=0100 at cycle 2; 9 absorb words pass through unchanged.
- Simultaneous requests: req=1011 with rr_ptr=0 → order is 0, 1, 3, 0 across successive sessions, each session held for 20 cycles then released.
- Mode switching: owner 0 (MODE_VEC bit 0=0) then owner 2 (bit 2=1) → shake_mode 0 then 1, with a force_rst pulse before each session.
- Isolation: non-owner drives in_valid=1 and absorb_next=1 during a session → core sees only owner traffic; the non-owner sees in_ready=0 and out_valid=0.
- Pass-through reset: owner pulses req_absorb_next for 1 cycle mid-session → shake_force_rst pulses in the same cycle and grant is retained.
- Reset during BUSY at cycle 5 → grant=0, state IDLE and rr_ptr=0 on the next cycle; a subsequent req=0010 is granted 2 cycles after being sampled in IDLE.
